// File: rtl/mem_pkg.sv
// Shared types for the processor memory interface: burst size encoding, responder FSM states.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: access_size_t (also used by the processor), mem_state_t, beats().
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_WORD   = 2'b00,
      SZ_4WORD  = 2'b01,
      SZ_8WORD  = 2'b10,
      SZ_16WORD = 2'b11
   } access_size_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2
   } mem_state_t;

   // Number of beats in a request of the given size.
   function automatic logic [4:0] beats(input access_size_t sz);
      case (sz)
         SZ_WORD:  return 5'd1;
         SZ_4WORD: return 5'd4;
         SZ_8WORD: return 5'd8;
         default:  return 5'd16;
      endcase
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one write or one read per cycle.
// Latency: read data appears on rdata one clock after the read is presented.
// Backpressure: none; rdata holds its value on cycles without a read.
// Ports: clk, reset (async active-low, clears rdata only), we/re, idx, wdata, rdata.
module mem_array #(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q, rdata_d;

   // Storage is never cleared. A write on an edge where reset is already low is dropped.
   always_ff @(posedge clk) begin
      if (we && reset) begin
         mem_q[idx] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= 32'd0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/burst_memory.sv
// Word-addressed burst responder for the processor's fetch/data port; owns the storage array.
// Latency: one cycle per beat, beats on consecutive cycles; next request accepted at T0+N.
// Backpressure: busy is high during a burst; requests seen while busy are ignored.
// Ports: clk, reset (async active-low), addr/data_in/access_size/rd_wr/enable in; data_out/busy/err out.
// Optional: define MEM_ADDR_CHECK_EN to reject misaligned or out-of-range requests with an err pulse.
module burst_memory
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
   parameter int          DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic [1:0]  access_size,
   input  logic        rd_wr,
   input  logic        enable,
   output logic [31:0] data_out,
   output logic        busy,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   mem_state_t    state_q, state_d;
   logic [3:0]    beat_q, beat_d;
   logic [3:0]    last_q, last_d;
   logic [AW-1:0] base_q, base_d;
   logic          err_q, err_d;

   logic [31:0]   byte_off;
   logic [AW-1:0] req_idx;
   logic [4:0]    n_beats;
   logic          reject;
   logic          mem_we, mem_re;
   logic [AW-1:0] mem_idx;

   // Translation: truncated unsigned subtraction, so indices wrap modulo the depth.
   assign byte_off = addr - BASE_ADDR;
   assign req_idx  = byte_off[AW+1:2];
   assign n_beats  = beats(access_size_t'(access_size));

`ifdef MEM_ADDR_CHECK_EN
   // Word offset is at most 2^30-1, so adding up to 16 cannot overflow 32 bits.
   // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
   assign reject = (addr[1:0] != 2'b00) ||
                   (({2'b00, byte_off[31:2]} + 32'(n_beats)) > 32'(DEPTH_WORDS));
   logic unused_off;
   assign unused_off = ^byte_off[1:0];
`else
   assign reject = 1'b0;
   logic unused_off;
   assign unused_off = ^{byte_off[31:AW+2], byte_off[1:0]};
`endif

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      last_d  = last_q;
      base_d  = base_q;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      mem_idx = req_idx;
      if (state_q == IDLE) begin
         if (enable) begin
            if (reject) begin
               err_d = 1'b1;
            end else begin
               // Beat 0 is served on the acceptance edge itself.
               mem_we = !rd_wr;
               mem_re = rd_wr;
               base_d = req_idx;
               last_d = 4'(n_beats - 5'd1);
               beat_d = 4'd0;
               if (n_beats != 5'd1) begin
                  state_d = rd_wr ? RD_BURST : WR_BURST;
                  beat_d  = 4'd1;
               end
            end
         end
      end else begin
         // Request inputs are ignored here; the burst runs to completion.
         mem_idx = base_q + AW'(beat_q);
         mem_we  = (state_q == WR_BURST);
         mem_re  = (state_q == RD_BURST);
         if (beat_q == last_q) begin
            state_d = IDLE;
            beat_d  = 4'd0;
         end else begin
            beat_d = beat_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         beat_q  <= 4'd0;
         last_q  <= 4'd0;
         base_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         last_q  <= last_d;
         base_q  <= base_d;
         err_q   <= err_d;
      end
   end

   mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .idx   (mem_idx),
      .wdata (data_in),
      .rdata (data_out)
   );

   assign busy = (state_q != IDLE);

`ifdef MEM_ADDR_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
   logic unused_err;
   assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_burst_memory.sv
// Directed bench for burst_memory with a read-data scoreboard.
// Latency: expects read data one cycle after each read beat edge.
// Backpressure: checks busy per cycle and that requests made while busy are ignored.
module tb_burst_memory;
   import mem_pkg::*;

   localparam logic [31:0] BASE  = 32'h8002_0000;
   localparam int          DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [1:0]  access_size;
   logic        rd_wr;
   logic        enable;
   logic [31:0] data_out;
   logic        busy;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_q [$];
   logic [31:0] last_rd;

   burst_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .addr        (addr),
      .data_in     (data_in),
      .access_size (access_size),
      .rd_wr       (rd_wr),
      .enable      (enable),
      .data_out    (data_out),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a, input int k);
      logic [31:0] w;
      w = ((a - BASE) >> 2) + 32'(k);
      return int'(w % DEPTH);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One accepted request; enable is held for the whole burst unless drop is set.
   task automatic burst(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d0, input bit drop);
      int n;
      n = int'(beats(access_size_t'(sz)));
      addr = a; access_size = sz; rd_wr = rw; enable = 1'b1; data_in = d0;
      for (int k = 0; k < n; k++) begin
         if (rw) exp_q.push_back(model_mem[widx(a, k)]);
         else    model_mem[widx(a, k)] = d0 + 32'(k);
      end
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (drop || k == n - 1) enable = 1'b0;
         data_in = d0 + 32'(k + 1);
         chk("busy", 32'(busy), (k < n - 1) ? 32'd1 : 32'd0);
         chk("err", 32'(err), 32'd0);
         if (rw) begin
            last_rd = exp_q.pop_front();
            chk("rd_data", data_out, last_rd);
         end else begin
            chk("wr_data_out_hold", data_out, last_rd);
         end
      end
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; addr = '0; data_in = '0;
      access_size = 2'b00; rd_wr = 1'b0; last_rd = 32'd0;
      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_data_out", data_out, 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      @(negedge clk); reset = 1'b1;

      // Fill the whole array so every later read has a known value.
      burst(1'b0, 2'b11, BASE, 32'h0000_1000, 1'b0);

      // Single-word write then read on the very next cycle.
      burst(1'b0, 2'b00, BASE, 32'hDEAD_BEEF, 1'b0);
      burst(1'b1, 2'b00, BASE, 32'h0, 1'b0);

      // 4-word write of 1..4 at word 4, then read back.
      burst(1'b0, 2'b01, 32'h8002_0010, 32'd1, 1'b0);
      burst(1'b1, 2'b01, 32'h8002_0010, 32'h0, 1'b0);

`ifndef MEM_ADDR_CHECK_EN
      // Low address bits are ignored: this reads word 4.
      burst(1'b1, 2'b00, 32'h8002_0013, 32'h0, 1'b0);
      // 8-word write at word 12 wraps onto words 0..3.
      burst(1'b0, 2'b10, 32'h8002_0030, 32'h0000_00A0, 1'b0);
`endif

      // 16-word read with enable dropped after T0; a single read of word 13
      // is parked on the inputs while busy and must be accepted only at T0+16.
      addr = BASE; access_size = 2'b11; rd_wr = 1'b1; enable = 1'b1;
      for (int k = 0; k < 16; k++) exp_q.push_back(model_mem[k]);
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         if (k == 0) enable = 1'b0;
         if (k == 4) begin
            enable = 1'b1; addr = BASE + 32'd52; access_size = 2'b00; rd_wr = 1'b1;
         end
         chk("b16_busy", 32'(busy), (k < 15) ? 32'd1 : 32'd0);
         last_rd = exp_q.pop_front();
         chk("b16_data", data_out, last_rd);
      end
      exp_q.push_back(model_mem[13]);
      @(posedge clk); #1;
      enable = 1'b0;
      last_rd = exp_q.pop_front();
      chk("parked_req_data", data_out, last_rd);
      chk("parked_req_busy", 32'(busy), 32'd0);

      // Reset in the middle of an 8-word read.
      addr = BASE + 32'd8; access_size = 2'b10; rd_wr = 1'b1; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      @(posedge clk); #1;
      chk("mid_burst_busy", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_reset_busy", 32'(busy), 32'd0);
      chk("mid_reset_data_out", data_out, 32'd0);
      chk("mid_reset_err", 32'(err), 32'd0);
      last_rd = 32'd0;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_idle", 32'(busy), 32'd0);
      // Storage survives reset.
      burst(1'b1, 2'b01, 32'h8002_0010, 32'h0, 1'b0);
      burst(1'b1, 2'b00, BASE, 32'h0, 1'b0);

`ifdef MEM_ADDR_CHECK_EN
      // Misaligned single read is rejected.
      addr = 32'h8002_0002; access_size = 2'b00; rd_wr = 1'b1; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      chk("chk_misalign_err", 32'(err), 32'd1);
      chk("chk_misalign_busy", 32'(busy), 32'd0);
      chk("chk_misalign_data", data_out, last_rd);
      @(posedge clk); #1;
      chk("chk_misalign_err_clr", 32'(err), 32'd0);
      // 4-word write starting at the last word runs off the end.
      addr = BASE + 32'(4 * (DEPTH - 1)); access_size = 2'b01; rd_wr = 1'b0;
      data_in = 32'h5555_5555; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      chk("chk_range_err", 32'(err), 32'd1);
      chk("chk_range_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("chk_range_err_clr", 32'(err), 32'd0);
      chk("chk_range_busy2", 32'(busy), 32'd0);
      burst(1'b1, 2'b00, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 1'b0);
      burst(1'b1, 2'b00, BASE, 32'h0, 1'b0);
`endif

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
